zigzag_scan8x8: RTL and testbench
=================================

Name: zigzag_scan8x8

Overview:
- Downstream stage of the 8x8 block loader.
- Accepts one 8x8 block of DW-bit samples, arriving in raster (row-major) order over a valid/ready stream, into an internal 64-entry buffer.
- Then replays the block in JPEG zig-zag order over a second valid/ready stream to the transform/entropy stage.
- Single buffer: fill and drain phases alternate and never overlap.

Parameters:
- DW, 16, sample width in bits.

Ports:
- clock  input  1  sole clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort: discard partial block, return to FILL.
- in_valid  input  1  upstream sample valid.
- in_data  input  DW  upstream sample, raster order.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  out_data holds a valid zig-zag sample.
- out_data  output  DW  zig-zag-ordered sample.
- out_ready  input  1  downstream accepts the sample.
- out_last  output  1  high with the 64th (final) sample of a block.
- block_done  output  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (asynchronous, active-high):
  - state=FILL, wcnt=0, rcnt=0, block_done=0.
  - Buffer contents are not cleared.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, out_last=0.
- States: FILL, DRAIN. Both counters are 6 bits (0..63).
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: mem[wcnt]<=in_data, wcnt<=wcnt+1.
  - Handshake with wcnt==63: wcnt wraps to 0, state<=DRAIN on the next edge.
  - No handshake: state holds. Gaps in in_valid are allowed anywhere.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_data = mem[ZZ[rcnt]], combinational from the registered buffer and rcnt.
  - Whenever out_valid=1 and out_ready=0, out_data must be held stable.
  - out_last = (rcnt==63).
  - On out_ready: rcnt<=rcnt+1.
  - Handshake with rcnt==63: rcnt wraps to 0, state<=FILL, block_done=1 for exactly the next cycle.
- Outside DRAIN: out_data=0, out_last=0.
- Latency:
  - First output is valid in the cycle after the 64th input handshake.
  - Throughput with no stalls: 64 in + 64 out = 128 cycles per block.
  - A new block's first input is accepted the cycle after the final output handshake.
- ZZ table: fixed 64-entry constant mapping zig-zag index to raster index (i*8+j). Standard JPEG order:
  - Starts 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- clear:
  - Synchronous, priority over all handshakes in that cycle.
  - Forces state=FILL, wcnt=0, rcnt=0, block_done=0.
  - The sample presented in that cycle is not written.
- Reset mid-block: partial data is discarded. The next accepted sample is raster index 0.
- No simultaneous in/out handshakes are possible; the phases are exclusive by construction.

Test Plan:
- Single block, no stalls:
  - Stimulus: in_data = raster index 0..63, out_ready=1.
  - Outputs 0,1,8,16,9,2,3,10,17,24,...,55,62,63.
  - out_last only with 63, block_done pulses once.
  - First out_valid is exactly 1 cycle after the 64th input handshake.
- Upstream gaps:
  - Stimulus: in_valid toggles 1/0 each cycle, data 0x1000+k.
  - All 64 samples captured; zig-zag output identical to the no-gap case plus 0x1000 offset.
- Downstream backpressure:
  - Stimulus: out_ready low for 3 cycles at zig-zag index 5 (value 2).
  - out_data holds 2 and out_valid stays 1 while stalled; the sequence resumes with 3; no drop or duplicate.
- In_ready blocking:
  - Stimulus: hold in_valid=1 throughout DRAIN.
  - in_ready=0 for all 64 drain cycles; no buffer overwrite (output matches the first block).
  - A second block with data 100+k follows with output 100,101,108,...
- Clear mid-fill:
  - Stimulus: write 30 samples, pulse clear, then write 64 samples 200+k.
  - Output begins 200,201,208; the old data never appears.
- Async reset mid-drain:
  - Stimulus: assert reset between clock edges at rcnt=20.
  - out_valid=0 and in_ready=1 immediately (before the next edge).
  - After release, a fresh block round-trips correctly.

Source files
------------

// File: rtl/zigzag_scan8x8.sv
// 8x8 block reorder buffer: captures 64 samples in raster order, then replays
// them in JPEG zig-zag order. One buffer; fill and drain phases alternate.
module zigzag_scan8x8 #(
    parameter int DW = 16
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i,
    output logic          out_last_o,
    output logic          block_done_o
);

    typedef enum logic {FILL, DRAIN} state_t;

    // Zig-zag index -> raster index (row*8 + col)
    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t        state_q;
    logic [5:0]    wcnt_q, rcnt_q, wcnt_d, rcnt_d;
    logic          done_q;
    logic [DW-1:0] mem_q [0:63];
    logic          in_hs, out_hs;

    assign in_hs  = in_valid_i  && (state_q == FILL);
    assign out_hs = out_ready_i && (state_q == DRAIN);
    assign wcnt_d = wcnt_q + 6'd1;
    assign rcnt_d = rcnt_q + 6'd1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_hs) begin
                wcnt_q <= wcnt_d;
                if (wcnt_q == 6'd63) state_q <= DRAIN;
            end
            if (out_hs) begin
                rcnt_q <= rcnt_d;
                if (rcnt_q == 6'd63) begin
                    state_q <= FILL;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    // Buffer is deliberately left uninitialised; a clear cycle writes nothing
    always_ff @(posedge clock_i) begin
        if (in_hs && !clear_i && !reset_i) mem_q[wcnt_q] <= in_data_i;
    end

    assign in_ready_o   = (state_q == FILL);
    assign out_valid_o  = (state_q == DRAIN);
    assign out_data_o   = (state_q == DRAIN) ? mem_q[ZZ[rcnt_q]] : '0;
    assign out_last_o   = (state_q == DRAIN) && (rcnt_q == 6'd63);
    assign block_done_o = done_q;

endmodule

// File: tb/tb_zigzag_scan8x8.sv
// Directed bench for zigzag_scan8x8: fill/drain round trips, gaps, stalls,
// clear and asynchronous reset.
module tb_zigzag_scan8x8;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_last, block_done;
    logic [15:0] out_data;

    int checks = 0;
    int failures = 0;

    int zz [0:63] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    zigzag_scan8x8 #(.DW(16)) dut (
        .clock_i(clk), .reset_i(rst), .clear_i(clr),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .out_last_o(out_last), .block_done_o(block_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n raster samples base+k; optional idle cycle after each one.
    task automatic push(input int base, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(base + k);
            chk("in_ready_fill", {31'b0, in_ready}, 32'd1);
            chk("out_valid_fill", {31'b0, out_valid}, 32'd0);
            tick();
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 16'hFFFF;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    // Drain n zig-zag samples expecting base+ZZ[i]; optionally stall at index
    // stall_at for 3 cycles and/or keep in_valid asserted with junk data.
    task automatic drain(input int base, input int n, input int stall_at, input bit hold_in);
        chk("first_out_valid", {31'b0, out_valid}, 32'd1);
        if (hold_in) begin
            in_valid = 1'b1;
            in_data  = 16'hDEAD;
        end
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_valid", {31'b0, out_valid}, 32'd1);
                    chk("stall_data", {16'b0, out_data}, 32'(base + zz[i]));
                end
            end
            out_ready = 1'b1;
            chk("out_valid", {31'b0, out_valid}, 32'd1);
            chk("out_data", {16'b0, out_data}, 32'(base + zz[i]));
            chk("out_last", {31'b0, out_last}, {31'b0, (i == 63)});
            if (hold_in) chk("in_ready_drain", {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (n == 64) begin
            chk("block_done_pulse", {31'b0, block_done}, 32'd1);
            chk("out_valid_after", {31'b0, out_valid}, 32'd0);
            chk("in_ready_after", {31'b0, in_ready}, 32'd1);
            chk("out_data_idle", {16'b0, out_data}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_block_done", {31'b0, block_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single block, no stalls; drain starts right after the 64th input
        push(0, 63, 1'b0);
        in_valid = 1'b1; in_data = 16'd63;
        chk("pre_last_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        drain(0, 64, -1, 1'b0);
        tick();
        chk("block_done_one_cycle", {31'b0, block_done}, 32'd0);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Upstream gaps
        push(16'h1000, 64, 1'b1);
        drain(16'h1000, 64, -1, 1'b0);

        // Downstream backpressure at zig-zag index 5 (value 2)
        push(0, 64, 1'b0);
        drain(0, 64, 5, 1'b0);

        // in_valid held high during drain; next block follows immediately
        push(0, 64, 1'b0);
        drain(0, 64, -1, 1'b1);
        push(100, 64, 1'b0);
        drain(100, 64, -1, 1'b0);

        // Clear mid-fill; the clear-cycle sample must not be written
        push(500, 30, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clear_in_ready", {31'b0, in_ready}, 32'd1);
        push(200, 64, 1'b0);
        drain(200, 64, -1, 1'b0);

        // Async reset mid-drain at rcnt=20
        push(0, 64, 1'b0);
        drain(0, 20, -1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_out_data", {16'b0, out_data}, 32'd0);
        chk("arst_out_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        push(300, 64, 1'b0);
        drain(300, 64, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
